// File: rtl/jalr_exec_unit_pkg.sv
// Shared definitions for the JALR execute unit:
// instruction IDs, exception causes and FSM state encodings.
package jalr_exec_unit_pkg;

  localparam int INST_ID_LEN = 4;

  localparam logic [INST_ID_LEN-1:0] NONE_ID = 4'd0;
  localparam logic [INST_ID_LEN-1:0] JALR_ID = 4'd9;

  localparam logic On  = 1'b1;
  localparam logic Off = 1'b0;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_WB    = 2'd2,
    ST_EXC   = 2'd3
  } jalr_state_e;

  function automatic logic is_jalr(
    input logic [INST_ID_LEN-1:0] id
  );
    return (id == JALR_ID);
  endfunction

endpackage

// File: rtl/jalr_exec_unit_target_calc.sv
// Combinational JALR target, link and alignment computation.
// Sums wrap modulo 2^XLEN; target bit 0 is always cleared.
module jalr_target_calc
  import jalr_exec_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] sum;

  assign sum      = rs1_i + imm_i;
  assign target_o = sum & ~XLEN'(1);
  assign link_o   = pc_i + XLEN'(4);

  // Bit 1 is only a legal target bit when compressed code exists.
  assign misalign_o = (C_EXT == Off) && target_o[1];

endmodule

// File: rtl/jalr_exec_unit.sv
// JALR execute unit: redirect, flush, link writeback or
// misaligned-target exception for each accepted JALR.
module jalr_exec_unit
  import jalr_exec_unit_pkg::*;
#(
  parameter int         XLEN           = 32,
  parameter bit         C_EXT          = 1'b0,
  parameter logic [3:0] MISALIGN_CAUSE = EXC_INSTR_MISALIGN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [INST_ID_LEN-1:0] id_instr_id,
  input  logic [XLEN-1:0]        id_pc,
  input  logic [XLEN-1:0]        id_rs1_data,
  input  logic [XLEN-1:0]        id_imm,
  input  logic [4:0]             id_rd,
  output logic                   id_ready,
  output logic                   redir_valid,
  output logic [XLEN-1:0]        redir_pc,
  input  logic                   redir_ready,
  output logic                   flush,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  input  logic                   wb_ready,
  output logic                   exc_valid,
  output logic [3:0]             exc_cause,
  output logic [XLEN-1:0]        exc_tval,
  input  logic                   exc_ack
);

  jalr_state_e     state_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] link_q;
  logic [4:0]      rd_q;

  logic [XLEN-1:0] calc_target;
  logic [XLEN-1:0] calc_link;
  logic            calc_misalign;
  logic            accept;
  logic            redir_fire;
  logic            exc_fire;

  jalr_target_calc #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_calc (
    .pc_i       (id_pc),
    .rs1_i      (id_rs1_data),
    .imm_i      (id_imm),
    .target_o   (calc_target),
    .link_o     (calc_link),
    .misalign_o (calc_misalign)
  );

  assign id_ready    = (state_q == ST_IDLE);
  assign redir_valid = (state_q == ST_REDIR);
  assign wb_valid    = (state_q == ST_WB);
  assign exc_valid   = (state_q == ST_EXC);

  assign accept     = id_valid & id_ready & is_jalr(id_instr_id);
  assign redir_fire = redir_valid & redir_ready;
  assign exc_fire   = exc_valid & exc_ack;

  // Payloads are zero while idle so reset leaves every output low.
  assign redir_pc  = redir_valid ? target_q : '0;
  assign wb_rd     = wb_valid ? rd_q : 5'd0;
  assign wb_data   = wb_valid ? link_q : '0;
  assign exc_tval  = exc_valid ? target_q : '0;
  assign exc_cause = exc_valid ? MISALIGN_CAUSE : 4'd0;
  assign flush     = redir_fire | exc_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      link_q   <= '0;
      rd_q     <= 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            target_q <= calc_target;
            link_q   <= calc_link;
            rd_q     <= id_rd;
            state_q  <= calc_misalign ? ST_EXC : ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (redir_ready) begin
            state_q <= (rd_q != 5'd0) ? ST_WB : ST_IDLE;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_EXC: begin
          if (exc_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jalr_exec_unit.sv
// Directed testbench for jalr_exec_unit (C_EXT=0 and C_EXT=1).
// Each scenario task drives vectors and checks inline.
module tb_jalr_exec_unit;
  import jalr_exec_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   id_valid = 1'b0;
  logic [INST_ID_LEN-1:0] id_instr_id = NONE_ID;
  logic [31:0]            id_pc = '0;
  logic [31:0]            id_rs1_data = '0;
  logic [31:0]            id_imm = '0;
  logic [4:0]             id_rd = '0;
  logic                   redir_ready = 1'b1;
  logic                   wb_ready = 1'b1;
  logic                   exc_ack = 1'b1;

  logic        id_ready, redir_valid, flush, wb_valid, exc_valid;
  logic [31:0] redir_pc, wb_data, exc_tval;
  logic [4:0]  wb_rd;
  logic [3:0]  exc_cause;

  logic        id_ready_c, redir_valid_c, flush_c, wb_valid_c, exc_valid_c;
  logic [31:0] redir_pc_c, wb_data_c, exc_tval_c;
  logic [4:0]  wb_rd_c;
  logic [3:0]  exc_cause_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jalr_exec_unit #(.XLEN(32), .C_EXT(1'b0), .MISALIGN_CAUSE(4'd0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_instr_id(id_instr_id), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_imm(id_imm), .id_rd(id_rd),
    .id_ready(id_ready),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .exc_ack(exc_ack)
  );

  jalr_exec_unit #(.XLEN(32), .C_EXT(1'b1), .MISALIGN_CAUSE(4'd0)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_instr_id(id_instr_id), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_imm(id_imm), .id_rd(id_rd),
    .id_ready(id_ready_c),
    .redir_valid(redir_valid_c), .redir_pc(redir_pc_c),
    .redir_ready(redir_ready),
    .flush(flush_c),
    .wb_valid(wb_valid_c), .wb_rd(wb_rd_c), .wb_data(wb_data_c),
    .wb_ready(wb_ready),
    .exc_valid(exc_valid_c), .exc_cause(exc_cause_c), .exc_tval(exc_tval_c),
    .exc_ack(exc_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_jalr(input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] imm, input logic [4:0] rd);
    id_valid    = 1'b1;
    id_instr_id = JALR_ID;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_imm      = imm;
    id_rd       = rd;
  endtask

  task automatic settle();
    id_valid    = 1'b0;
    id_instr_id = NONE_ID;
    redir_ready = 1'b1;
    wb_ready    = 1'b1;
    exc_ack     = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++; $display("FAIL reset_id_ready got=%b exp=1", id_ready);
    end
    checks++;
    if ({redir_valid, wb_valid, exc_valid, flush} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valids got=%b exp=0000",
               {redir_valid, wb_valid, exc_valid, flush});
    end
    checks++;
    if ({redir_pc, wb_data, exc_tval} !== 96'd0) begin
      failures++; $display("FAIL reset_payloads got=%h exp=0",
                           {redir_pc, wb_data, exc_tval});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_jalr(32'h200, 32'h1000, 32'h10, 5'd1);
    tick();
    id_valid = 1'b0;
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h1010) begin
      failures++; $display("FAIL basic_redir got=%b/%h exp=1/00001010",
                           redir_valid, redir_pc);
    end
    checks++;
    if (flush !== 1'b1 || id_ready !== 1'b0) begin
      failures++; $display("FAIL basic_flush_n1 got=%b/%b exp=1/0",
                           flush, id_ready);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'h204) begin
      failures++; $display("FAIL basic_wb got=%b/%0d/%h exp=1/1/00000204",
                           wb_valid, wb_rd, wb_data);
    end
    checks++;
    if (flush !== 1'b0 || redir_valid !== 1'b0) begin
      failures++; $display("FAIL basic_n2_quiet got=%b/%b exp=0/0",
                           flush, redir_valid);
    end
    tick();
    checks++;
    if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL basic_idle_n3 got=%b/%b exp=1/0",
                           id_ready, wb_valid);
    end
    settle();
  endtask

  task automatic test_wrap();
    drive_jalr(32'h0, 32'hFFFF_FFFF, 32'h4, 5'd0);
    tick();
    id_valid = 1'b0;
    checks++;
    if (redir_valid_c !== 1'b1 || redir_pc_c !== 32'h2) begin
      failures++; $display("FAIL wrap_redir_c got=%b/%h exp=1/00000002",
                           redir_valid_c, redir_pc_c);
    end
    checks++;
    if (exc_valid !== 1'b1 || exc_tval !== 32'h2) begin
      failures++; $display("FAIL wrap_exc got=%b/%h exp=1/00000002",
                           exc_valid, exc_tval);
    end
    settle();
  endtask

  task automatic test_misalign();
    exc_ack = 1'b0;
    drive_jalr(32'h300, 32'h1000, 32'h2, 5'd3);
    tick();
    id_valid = 1'b0;
    checks++;
    if (exc_valid !== 1'b1 || exc_tval !== 32'h1002 || exc_cause !== 4'd0) begin
      failures++;
      $display("FAIL misalign_exc got=%b/%h/%0d exp=1/00001002/0",
               exc_valid, exc_tval, exc_cause);
    end
    checks++;
    if ({redir_valid, wb_valid, flush} !== 3'b000) begin
      failures++; $display("FAIL misalign_no_redir got=%b exp=000",
                           {redir_valid, wb_valid, flush});
    end
    checks++;
    if (redir_valid_c !== 1'b1 || redir_pc_c !== 32'h1002) begin
      failures++; $display("FAIL misalign_cext_redir got=%b/%h exp=1/00001002",
                           redir_valid_c, redir_pc_c);
    end
    tick();
    checks++;
    if (exc_valid !== 1'b1 || exc_tval !== 32'h1002 ||
        {redir_valid, wb_valid, flush} !== 3'b000) begin
      failures++;
      $display("FAIL misalign_hold got=%b/%h/%b exp=1/00001002/000",
               exc_valid, exc_tval, {redir_valid, wb_valid, flush});
    end
    exc_ack = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++; $display("FAIL misalign_ack_flush got=%b exp=1", flush);
    end
    tick();
    exc_ack = 1'b0;
    #1;
    checks++;
    if ({exc_valid, wb_valid, flush, id_ready} !== 4'b0001) begin
      failures++; $display("FAIL misalign_after got=%b exp=0001",
                           {exc_valid, wb_valid, flush, id_ready});
    end
    settle();
  endtask

  task automatic test_backpressure();
    redir_ready = 1'b0;
    drive_jalr(32'h80, 32'h400, 32'h20, 5'd0);
    tick();
    id_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (redir_valid !== 1'b1 || redir_pc !== 32'h420 || id_ready !== 1'b0 ||
          flush !== 1'b0 || wb_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%b/%h/%b/%b/%b exp=1/00000420/0/0/0",
                 i, redir_valid, redir_pc, id_ready, flush, wb_valid);
      end
      tick();
    end
    redir_ready = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || redir_pc !== 32'h420) begin
      failures++; $display("FAIL bp_handshake got=%b/%h exp=1/00000420",
                           flush, redir_pc);
    end
    tick();
    checks++;
    if ({id_ready, redir_valid, flush, wb_valid} !== 4'b1000) begin
      failures++; $display("FAIL bp_after got=%b exp=1000",
                           {id_ready, redir_valid, flush, wb_valid});
    end
    settle();
  endtask

  task automatic test_back_to_back();
    drive_jalr(32'h10, 32'h3000, 32'h8, 5'd0);
    tick();
    drive_jalr(32'h14, 32'h5000, 32'hC, 5'd0);
    checks++;
    if (redir_pc !== 32'h3008 || flush !== 1'b1) begin
      failures++; $display("FAIL b2b_first got=%h/%b exp=00003008/1",
                           redir_pc, flush);
    end
    tick();
    checks++;
    if (id_ready !== 1'b1 || redir_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got=%b/%b exp=1/0",
                           id_ready, redir_valid);
    end
    tick();
    id_valid = 1'b0;
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h500C) begin
      failures++; $display("FAIL b2b_second got=%b/%h exp=1/0000500c",
                           redir_valid, redir_pc);
    end
    settle();
  endtask

  task automatic test_none_id();
    id_valid    = 1'b1;
    id_instr_id = NONE_ID;
    id_rs1_data = 32'h1000;
    id_imm      = 32'h10;
    id_rd       = 5'd2;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) id_instr_id = 4'd5;
      tick();
      checks++;
      if ({id_ready, redir_valid, wb_valid, exc_valid, flush} !== 5'b10000) begin
        failures++; $display("FAIL none_id_%0d got=%b exp=10000", i,
                             {id_ready, redir_valid, wb_valid, exc_valid, flush});
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    drive_jalr(32'h400, 32'h2000, 32'h4, 5'd5);
    tick();
    id_valid = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h404) begin
      failures++; $display("FAIL rstmid_wb got=%b/%0d/%h exp=1/5/00000404",
                           wb_valid, wb_rd, wb_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({redir_valid, wb_valid, exc_valid, flush} !== 4'b0000 ||
        id_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_async got=%b/%b exp=0000/1",
                           {redir_valid, wb_valid, exc_valid, flush}, id_ready);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({redir_valid, wb_valid, exc_valid, flush} !== 4'b0000) begin
        failures++; $display("FAIL rstmid_quiet_%0d got=%b exp=0000", i,
                             {redir_valid, wb_valid, exc_valid, flush});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_misalign();
    test_backpressure();
    test_back_to_back();
    test_none_id();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
